// File: rtl/pwm_line_sequencer.sv
// Purpose: accepts one line of per-channel PWM duty values into a shadow bank,
//          runs the shared 8-bit PWM count / hsync window and swaps the shadow
//          bank into the active bank (pwm_data) in the one-cycle GAP between
//          line periods.
// Latency: line period is 257 cycles (256 RUN + 1 GAP); pwm_data updates on the
//          edge leaving GAP; all outputs registered except s_ready.
// Backpressure: s_ready drops once a full line sits in the shadow bank and rises
//          again the cycle after the GAP that consumes it.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   run_en         enable, sampled in IDLE and GAP only
//   s_valid/s_ready/s_data/s_last
//                  duty beat stream, channel 0 first, s_last may end a line early
//   count          shared PWM count (0..255 during RUN, 0 otherwise)
//   hsync          high during RUN
//   pwm_data       active bank, channel i at [8i+7:8i]
//   underrun       one-cycle pulse during a GAP that found no complete line
//   line_cnt       number of lines swapped in (wraps)
//
// Build option: PWM_SEQ_REPEAT_EN defined -> an underrun repeats the previous
// line; undefined -> an underrun blanks the active bank.

module pwm_line_sequencer #(
    parameter int CHANNELS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run_en,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [7:0]              s_data,
    input  logic                    s_last,
    output logic [7:0]              count,
    output logic                    hsync,
    output logic [8*CHANNELS-1:0]   pwm_data,
    output logic                    underrun,
    output logic [15:0]             line_cnt
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      shadow [CHANNELS];
    logic [PW-1:0]   wptr;
    logic            shadow_full;
    logic            shadow_full_nxt;

    logic            accept;
    logic            beat_end;
    logic            swap;
`ifndef PWM_SEQ_REPEAT_EN
    logic            blank;
`endif

    assign s_ready  = !shadow_full && !rst;
    assign accept   = s_valid && s_ready;
    // A line ends on the last channel slot or on an early s_last.
    assign beat_end = accept && ((wptr == PW'(CHANNELS-1)) || s_last);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run_en && shadow_full) state_nxt = GAP;
            RUN:     if (count == 8'hFF)        state_nxt = GAP;
            GAP:     state_nxt = run_en ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: output / control decode ----------------
    always_comb begin
        swap = (state == GAP) && shadow_full;
`ifndef PWM_SEQ_REPEAT_EN
        blank = (state == GAP) && !shadow_full;
`endif
        // Swap and line completion never coincide: s_ready is low while
        // shadow_full is set, and swap needs shadow_full set. A line completing
        // during a GAP is therefore held for the next GAP.
        shadow_full_nxt = shadow_full;
        if (beat_end) begin
            shadow_full_nxt = 1'b1;
        end else if (swap) begin
            shadow_full_nxt = 1'b0;
        end
    end

    // ---------------- shadow bank load ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            shadow_full <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= 8'd0;
            end
        end else begin
            shadow_full <= shadow_full_nxt;
            if (accept) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (int'(wptr) == i) begin
                        shadow[i] <= s_data;
                    end else if (s_last && (i > int'(wptr))) begin
                        // Early end of line: blank the channels not supplied.
                        shadow[i] <= 8'd0;
                    end
                end
                if (beat_end) begin
                    wptr <= '0;
                end else begin
                    wptr <= wptr + 1'b1;
                end
            end
        end
    end

    // ---------------- period timing and active bank ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 8'd0;
            hsync    <= 1'b0;
            pwm_data <= '0;
            underrun <= 1'b0;
            line_cnt <= 16'd0;
        end else begin
            count    <= ((state == RUN) && (state_nxt == RUN)) ? count + 8'd1 : 8'd0;
            hsync    <= (state_nxt == RUN);
            // Registered so it is high during the GAP cycle itself: predict it
            // from the shadow_full value that GAP will see.
            underrun <= (state_nxt == GAP) && !shadow_full_nxt;
            if (swap) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    pwm_data[8*i +: 8] <= shadow[i];
                end
                line_cnt <= line_cnt + 16'd1;
            end
`ifndef PWM_SEQ_REPEAT_EN
            else if (blank) begin
                pwm_data <= '0;
            end
`endif
        end
    end

endmodule

// File: doc/pwm_line_sequencer.md
# pwm_line_sequencer

Sequencer for the PWM display datapath: it accepts per-line channel duty values over a valid/ready stream and holds them in a shadow bank. It generates the shared 8-bit PWM count and the active-high `hsync` line window, and swaps the shadow bank into the active bank at each period boundary. It sits between the pixel/line source and an array of `CHANNELS` PWM blocks, which consume `count`, `hsync` and one 8-bit slice of `pwm_data` each.

## Interface
- `CHANNELS`, 8: number of PWM channels per line (2..32).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `run_en`  input  1  enable; sampled in IDLE and GAP only.
- `s_valid`  input  1  duty beat valid.
- `s_ready`  output  1  duty beat accepted when `s_valid && s_ready`.
- `s_data`  input  8  duty value for the next channel, channel 0 first.
- `s_last`  input  1  final beat of a line.
- `count`  output  8  shared PWM count to all PWM blocks.
- `hsync`  output  1  high while a line period is running (RUN).
- `pwm_data`  output  8*CHANNELS  active bank; channel i at bits [8i+7:8i].
- `underrun`  output  1  one-cycle pulse: GAP found no complete shadow line.
- `line_cnt`  output  16  count of lines swapped in; wraps 65535 -> 0.

## Operation
- Reset: state=IDLE, `count`=0, `hsync`=0, `pwm_data`=0, shadow bank=0, write pointer `wptr`=0, `shadow_full`=0, `underrun`=0, `line_cnt`=0. `s_ready`=0 while `rst`=1.
- `s_ready` = !`shadow_full` (combinational, gated by `rst`).
- Load: each accepted beat writes `s_data` to shadow[`wptr`], and `wptr` increments.
  - Beat with `wptr`==CHANNELS-1: `shadow_full`<=1, `wptr`<=0; `s_last` is ignored.
  - `s_last` on an earlier beat: shadows [`wptr`+1..CHANNELS-1] <=0 in the same cycle, `shadow_full`<=1, `wptr`<=0.
- FSM states: IDLE, RUN, GAP.
  - IDLE: `hsync`=0, `count`=0. Go to GAP when `run_en` && `shadow_full`.
  - GAP (exactly 1 cycle): `hsync`=0, `count`=0.
    - If `shadow_full` (registered value): active<=shadow, `shadow_full`<=0, `line_cnt`++.
    - Else: underrun handling (see Configuration), with `underrun`=1 for this cycle.
    - Next state is RUN if `run_en`, else IDLE.
  - RUN: `hsync`=1. `count` starts at 0 and increments each cycle; at `count`==255 the next state is GAP.
- Simultaneous events:
  - A beat completing the shadow bank during GAP is not swapped this GAP; the bank is held for the next one.
  - Because `shadow_full` clears on swap, `s_ready` rises the cycle after GAP.
  - `run_en` deassertion during RUN does not truncate the period.
- `rst` mid-operation: everything returns to reset values on the next edge. A partially loaded line is discarded.

## Timing
- Line period is 257 cycles: RUN 256 cycles (`count` 0..255) plus GAP 1 cycle.
- `pwm_data` changes only on the edge leaving GAP. It is stable for the whole RUN.
- First line latency: the cycle after `shadow_full` rises with `run_en`=1 is GAP; RUN follows with `count`=0 and the new `pwm_data` valid.
- `hsync` falls on the edge after `count`==255 and rises one cycle later.
- All outputs are registered except `s_ready`.

## Configuration
- `PWM_SEQ_REPEAT_EN` defined: on underrun in GAP, the active bank is kept (the previous line repeats).
- `PWM_SEQ_REPEAT_EN` undefined: on underrun in GAP, the active bank is cleared to 0 (blank line).
- In both cases: `underrun` pulses and `line_cnt` does not increment.

## Test plan
- Reset, then `run_en`=1 and 8 beats 10,20..80 back-to-back.
  - Required: `s_ready` low after the 8th beat, one GAP cycle, then RUN with `pwm_data` channel 0=10 and channel 7=80, `count` 0..255, `hsync`=1, `line_cnt`=1.
- 3 beats (5,6,7) with `s_last` on the 3rd.
  - Required: channels 0..2=5,6,7 and channels 3..7=0 after the swap.
- Second line loaded during RUN.
  - Required: swap happens at the next GAP, exactly 257 cycles after the first RUN start, and `pwm_data` is constant throughout each RUN.
- No second line supplied.
  - Required: at the GAP, `underrun`=1 for 1 cycle and `line_cnt` stays 1.
  - With `PWM_SEQ_REPEAT_EN`: `pwm_data` unchanged. Without it: `pwm_data`=0.
- `run_en` dropped at `count`=100.
  - Required: RUN completes to 255, GAP, then IDLE with `hsync`=0 and `count`=0.
- `rst` asserted for 1 cycle at `count`=128 with 4 beats loaded in shadow.
  - Required: all outputs return to reset values, and reloading starts at channel 0.
